uart_host_ctrl: RTL and testbench
=================================

# uart_host_ctrl

Host-side sequencer for the UART core. It shares the UART transmit path between two byte requesters using round-robin arbitration. It generates the UART's CSN/WEN/OEN register strobes, polls RXRDY, and moves received bytes with their error flags into a valid/ready output buffer. It sits between the application logic (for example the INA220 telemetry formatter and the command responder) and the UART's CPU-style interface.

## Interface
Parameters:
- TXRDY_WAIT, default 2: cycles spent in TXHOLD after a write strobe before TXRDY is sampled again. Legal range 1..15.
- RD_WAIT, default 2: cycles spent in RXHOLD after a read strobe before RXRDY is sampled again. Legal range 1..15.

Ports:
- CLK  in  1  system clock; one clock domain.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ0_VALID / REQ1_VALID  in  1  requester has a byte to send.
- REQ0_DATA / REQ1_DATA  in  8  byte to send; held stable while VALID=1.
- REQ0_READY / REQ1_READY  out  1  one-cycle accept pulse.
- RX_VALID  out  1  RX_DATA/RX_ERR hold an unconsumed byte.
- RX_DATA  out  8  received byte.
- RX_ERR  out  3  {framing, parity, overflow} captured with the byte.
- RX_READY  in  1  consumer accepts the byte.
- UART_CSN, UART_WEN, UART_OEN  out  1  active-low strobes to the UART.
- UART_DATA_IN  out  8  write data to the UART.
- UART_DATA_OUT  in  8  read data from the UART.
- UART_TXRDY, UART_RXRDY, UART_PARITY_ERR, UART_FRAMING_ERR, UART_OVERFLOW  in  1  UART status.

## Operation
- All outputs are registered.
- Reset values: UART_CSN=1, UART_WEN=1, UART_OEN=1, UART_DATA_IN=0, REQn_READY=0, RX_VALID=0, RX_DATA=0, RX_ERR=0, state=IDLE, wait counter=0, last_grant=1 (so REQ0 wins the first tie).
- FSM states: IDLE, WRITE, TXHOLD, READ, RXHOLD.
- IDLE, read priority: if UART_RXRDY=1 and RX_VALID=0, go to READ. Reads take priority over writes.
- IDLE, write: otherwise, if UART_TXRDY=1 and any REQn_VALID=1, grant and go to WRITE. The FSM registers the granted REQn_DATA into UART_DATA_IN, pulses the granted REQn_READY for one cycle (coincident with WRITE), and updates last_grant.
- Arbitration: if only one requester is valid, it is granted. If both are valid, the requester that is not last_grant is granted.
- WRITE: UART_CSN=0 and UART_WEN=0 for exactly one cycle, then go to TXHOLD.
- TXHOLD: the counter counts TXRDY_WAIT cycles and ignores TXRDY, then the FSM returns to IDLE.
- READ: UART_CSN=0 and UART_OEN=0 for exactly one cycle. At the closing edge, UART_DATA_OUT goes to RX_DATA and {FRAMING_ERR, PARITY_ERR, OVERFLOW} go to RX_ERR. RX_VALID is set and the FSM goes to RXHOLD.
- RXHOLD: the FSM waits RD_WAIT cycles, then returns to IDLE.
- RX buffer: RX_VALID clears on the edge where RX_VALID=1 and RX_READY=1. While RX_VALID=1, no reads are issued. Any UART overrun during that time is reported through RX_ERR[0] on the next byte read.
- Strobes are mutually exclusive. WEN and OEN are never low in the same cycle, and CSN is low only in WRITE or READ.
- Asynchronous reset mid-transaction forces all outputs to their reset values immediately.
  - A request whose READY already pulsed counts as consumed.
  - A request whose READY has not pulsed is re-arbitrated after reset.
- Valid deasserted in IDLE before a grant: no write is issued.
- Both UART_RXRDY=1 and a pending write in IDLE: the read goes first, and the write follows after RXHOLD.

## Timing
- Write: request valid with TXRDY=1 sampled in IDLE at edge t.
  - REQn_READY=1 and WEN/CSN low during cycle t+1.
  - Back in IDLE at t+2+TXRDY_WAIT.
  - Minimum byte-to-byte spacing is 2+TXRDY_WAIT cycles (4 with the default).
- Read: RXRDY sampled in IDLE at edge t.
  - OEN/CSN low during cycle t+1.
  - RX_VALID=1 from cycle t+2.
  - Next RXRDY sample at t+2+RD_WAIT.
- The wait counter is 4 bits wide. It loads the parameter value on state entry and leaves the hold state when it reaches 1. The counter does not wrap.

## Test plan
- Reset: hold RESET_N=0 with arbitrary inputs. Required: CSN/WEN/OEN=1, RX_VALID=0, REQn_READY=0, UART_DATA_IN=0.
- Single write: REQ0_VALID=1, REQ0_DATA=8'hA5, TXRDY=1. Required: one REQ0_READY pulse, one WEN/CSN low cycle with UART_DATA_IN=8'hA5, next grant no earlier than 4 cycles later.
- Round-robin: both requesters valid continuously with data 8'h11 and 8'h22, TXRDY=1. Required: UART writes 11,22,11,22 in that order, exactly one READY pulse per write.
- Read with errors: UART_RXRDY=1, DATA_OUT=8'h3C, PARITY_ERR=1. Required: one OEN low cycle, then RX_VALID=1 with RX_DATA=8'h3C and RX_ERR=3'b010, held until RX_READY=1.
- Backpressure and priority: hold RX_READY=0 with RXRDY=1 and a pending REQ1 write. Required: exactly one read is issued, then REQ1 is written, and no further OEN strobes occur until RX_READY=1.
- Reset mid-write: assert RESET_N=0 during TXHOLD. Required: immediate reset values on all outputs, and a still-valid requester is re-granted after release.

Source files
------------

// File: rtl/uart_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_host_ctrl
// Purpose  : Host-side sequencer for a CPU-style UART core. Shares the UART
//            transmit path between two byte requesters using round-robin
//            arbitration. Generates the active-low CSN/WEN/OEN strobes, polls
//            RXRDY, and moves received bytes plus their error flags into a
//            single-entry valid/ready output buffer.
//
// Parameters
//   TXRDY_WAIT  cycles spent in TXHOLD after a write strobe (1..15)
//   RD_WAIT     cycles spent in RXHOLD after a read strobe  (1..15)
//
// Ports
//   clk, rst_n                system clock, asynchronous active-low reset
//   req{0,1}_valid_i/data_i   requester byte offer (data stable while valid)
//   req{0,1}_ready_o          one-cycle accept pulse, coincident with WRITE
//   rx_valid_o/data_o/err_o   received byte buffer, err = {frm, par, ovf}
//   rx_ready_i                consumer accepts the buffered byte
//   uart_csn_o/wen_o/oen_o    active-low UART register strobes
//   uart_data_in_o            write data to the UART
//   uart_data_out_i           read data from the UART
//   uart_txrdy_i, uart_rxrdy_i, uart_parity_err_i, uart_framing_err_i,
//   uart_overflow_i           UART status inputs
//
// Revision : 1.0  initial release
// ============================================================================
module uart_host_ctrl #(
    parameter int TXRDY_WAIT = 2,
    parameter int RD_WAIT    = 2
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid_i,
    input  logic [7:0] req0_data_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_data_i,
    output logic       req1_ready_o,

    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic [2:0] rx_err_o,
    input  logic       rx_ready_i,

    output logic       uart_csn_o,
    output logic       uart_wen_o,
    output logic       uart_oen_o,
    output logic [7:0] uart_data_in_o,
    input  logic [7:0] uart_data_out_i,
    input  logic       uart_txrdy_i,
    input  logic       uart_rxrdy_i,
    input  logic       uart_parity_err_i,
    input  logic       uart_framing_err_i,
    input  logic       uart_overflow_i
);

    // Hold lengths are clamped into the 4-bit counter's usable range so an
    // out-of-range parameter can neither wrap the counter nor give a zero
    // length hold.
    function automatic logic [3:0] clamp_wait(input int value);
        if (value < 1) begin
            return 4'd1;
        end else if (value > 15) begin
            return 4'd15;
        end else begin
            return 4'(value);
        end
    endfunction

    localparam logic [3:0] c_tx_wait = clamp_wait(TXRDY_WAIT);
    localparam logic [3:0] c_rd_wait = clamp_wait(RD_WAIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_TXHOLD = 3'd2,
        S_READ   = 3'd3,
        S_RXHOLD = 3'd4
    } state_t;

    state_t     state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic       last_q,      last_d;      // 1: requester 1 was granted last
    logic       csn_q,       csn_d;
    logic       wen_q,       wen_d;
    logic       oen_q,       oen_d;
    logic [7:0] data_in_q,   data_in_d;
    logic       rdy0_q,      rdy0_d;
    logic       rdy1_q,      rdy1_d;
    logic       rx_valid_q,  rx_valid_d;
    logic [7:0] rx_data_q,   rx_data_d;
    logic [2:0] rx_err_q,    rx_err_d;

    logic       w_any_req;
    logic       w_grant1;

    assign w_any_req = req0_valid_i | req1_valid_i;
    // A lone requester always wins; on a tie the one not served last wins.
    assign w_grant1  = req1_valid_i & (~req0_valid_i | ~last_q);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            last_q     <= 1'b1;
            csn_q      <= 1'b1;
            wen_q      <= 1'b1;
            oen_q      <= 1'b1;
            data_in_q  <= 8'h00;
            rdy0_q     <= 1'b0;
            rdy1_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_err_q   <= 3'b000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            csn_q      <= csn_d;
            wen_q      <= wen_d;
            oen_q      <= oen_d;
            data_in_q  <= data_in_d;
            rdy0_q     <= rdy0_d;
            rdy1_q     <= rdy1_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Every output is registered, so the
    // strobes and READY pulses for a state are computed on entry to it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        csn_d      = 1'b1;
        wen_d      = 1'b1;
        oen_d      = 1'b1;
        data_in_d  = data_in_q;
        rdy0_d     = 1'b0;
        rdy1_d     = 1'b0;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        rx_err_d   = rx_err_q;

        // Consumer handshake on the receive buffer.
        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // Reads win over writes; the buffer must be empty so that a
                // byte is never overwritten before it is consumed.
                if (uart_rxrdy_i && !rx_valid_q) begin
                    state_d = S_READ;
                    csn_d   = 1'b0;
                    oen_d   = 1'b0;
                end else if (uart_txrdy_i && w_any_req) begin
                    state_d   = S_WRITE;
                    csn_d     = 1'b0;
                    wen_d     = 1'b0;
                    data_in_d = w_grant1 ? req1_data_i : req0_data_i;
                    rdy0_d    = ~w_grant1;
                    rdy1_d    = w_grant1;
                    last_d    = w_grant1;
                end
            end

            S_WRITE: begin
                state_d = S_TXHOLD;
                cnt_d   = c_tx_wait;
            end

            S_TXHOLD: begin
                // TXRDY is deliberately ignored here: the UART needs a few
                // cycles before its status reflects the byte just written.
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_READ: begin
                // Data and error flags are captured on the edge that closes
                // the OEN strobe.
                state_d    = S_RXHOLD;
                cnt_d      = c_rd_wait;
                rx_valid_d = 1'b1;
                rx_data_d  = uart_data_out_i;
                rx_err_d   = {uart_framing_err_i, uart_parity_err_i, uart_overflow_i};
            end

            S_RXHOLD: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign req0_ready_o   = rdy0_q;
    assign req1_ready_o   = rdy1_q;
    assign rx_valid_o     = rx_valid_q;
    assign rx_data_o      = rx_data_q;
    assign rx_err_o       = rx_err_q;
    assign uart_csn_o     = csn_q;
    assign uart_wen_o     = wen_q;
    assign uart_oen_o     = oen_q;
    assign uart_data_in_o = data_in_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_host_ctrl
// Purpose  : Self-checking bench for uart_host_ctrl. A transaction-timing
//            reference model predicts, edge by edge, when reads and writes
//            start, which requester is granted and what the receive buffer
//            holds; directed scenarios are followed by randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_host_ctrl;

    localparam int TXW = 2;
    localparam int RDW = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       r0, r1;
    logic       rxv;
    logic [7:0] rxd;
    logic [2:0] rxe;
    logic       rx_ready = 1'b0;
    logic       csn, wen, oen;
    logic [7:0] din;
    logic [7:0] dout = 8'h00;
    logic       txrdy = 1'b0, rxrdy = 1'b0, pe = 1'b0, fe = 1'b0, ov = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_host_ctrl #(.TXRDY_WAIT(TXW), .RD_WAIT(RDW)) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req0_valid_i      (v0),
        .req0_data_i       (d0),
        .req0_ready_o      (r0),
        .req1_valid_i      (v1),
        .req1_data_i       (d1),
        .req1_ready_o      (r1),
        .rx_valid_o        (rxv),
        .rx_data_o         (rxd),
        .rx_err_o          (rxe),
        .rx_ready_i        (rx_ready),
        .uart_csn_o        (csn),
        .uart_wen_o        (wen),
        .uart_oen_o        (oen),
        .uart_data_in_o    (din),
        .uart_data_out_i   (dout),
        .uart_txrdy_i      (txrdy),
        .uart_rxrdy_i      (rxrdy),
        .uart_parity_err_i (pe),
        .uart_framing_err_i(fe),
        .uart_overflow_i   (ov)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: transaction start times follow the timing rules
    // (a write or read decided at edge e occupies the bus until edge
    // e+2+WAIT, a read captures at edge e+1).
    // ------------------------------------------------------------------
    int         edge_n    = 0;
    int         free_edge = 0;
    int         cap_edge  = -1;
    bit         m_last    = 1'b1;
    bit         m_rxv     = 1'b0;
    logic [7:0] m_rxd     = 8'h00;
    logic [2:0] m_rxe     = 3'b000;
    logic [7:0] m_din     = 8'h00;

    logic [7:0] wr_log[$];
    int n_oen = 0, n_r0 = 0, n_r1 = 0;
    int last_wr_edge = 0, last_rd_edge = 0;

    task automatic model_reset();
        m_last    = 1'b1;
        m_rxv     = 1'b0;
        m_rxd     = 8'h00;
        m_rxe     = 3'b000;
        m_din     = 8'h00;
        free_edge = 0;
        cap_edge  = -1;
    endtask

    // Advance one clock edge, update the model from the inputs the DUT just
    // sampled, then compare all outputs 1 ns after the edge.
    task automatic step();
        bit rd, wr, g;
        @(posedge clk);
        edge_n++;
        rd = 1'b0; wr = 1'b0; g = 1'b0;
        if (rst_n) begin
            if (edge_n >= free_edge) begin
                if (rxrdy && !m_rxv) begin
                    rd        = 1'b1;
                    free_edge = edge_n + 2 + RDW;
                    cap_edge  = edge_n + 1;
                end else if (txrdy && (v0 || v1)) begin
                    wr        = 1'b1;
                    g         = (v0 && v1) ? ~m_last : v1;
                    m_last    = g;
                    m_din     = g ? d1 : d0;
                    free_edge = edge_n + 2 + TXW;
                end
            end
            if (m_rxv && rx_ready) m_rxv = 1'b0;
            if (edge_n == cap_edge) begin
                m_rxv = 1'b1;
                m_rxd = dout;
                m_rxe = {fe, pe, ov};
            end
        end
        #1;
        check_val("strobes", 32'({csn, wen, oen}), 32'({~(rd | wr), ~wr, ~rd}));
        check_val("ready", 32'({r0, r1}), 32'({wr & ~g, wr & g}));
        check_val("data_in", 32'(din), 32'(m_din));
        check_val("rx_buf", 32'({rxv, rxd, rxe}), 32'({m_rxv, m_rxd, m_rxe}));
        if (!wen) begin wr_log.push_back(din); last_wr_edge = edge_n; end
        if (!oen) begin n_oen++; last_rd_edge = edge_n; end
        if (r0) n_r0++;
        if (r1) n_r1++;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must change at once.
    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        check_val("rst_immediate", 32'({csn, wen, oen, r0, r1, din, rxv, rxd, rxe}),
                  32'({3'b111, 2'b00, 8'h00, 1'b0, 8'h00, 3'b000}));
        model_reset();
    endtask

    task automatic release_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(output bit got0, output bit got1, output bit ok);
        ok = 1'b0; got0 = 1'b0; got1 = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if (r0 || r1) begin ok = 1'b1; got0 = r0; got1 = r1; end
        end
    endtask

    task automatic drive_random();
        if (r0) begin
            v0 = 1'($urandom_range(0, 1)); d0 = 8'($urandom);
        end else if (!v0) begin
            if ($urandom_range(0, 2) == 0) begin v0 = 1'b1; d0 = 8'($urandom); end
        end else if ($urandom_range(0, 15) == 0) begin
            v0 = 1'b0;
        end
        if (r1) begin
            v1 = 1'($urandom_range(0, 1)); d1 = 8'($urandom);
        end else if (!v1) begin
            if ($urandom_range(0, 2) == 0) begin v1 = 1'b1; d1 = 8'($urandom); end
        end else if ($urandom_range(0, 15) == 0) begin
            v1 = 1'b0;
        end
        txrdy    = ($urandom_range(0, 3) != 0);
        rxrdy    = ($urandom_range(0, 2) == 0);
        dout     = 8'($urandom);
        {fe, pe, ov} = 3'($urandom);
        rx_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int  first_r, second_r;
        bit  g0, g1, ok;
        logic [7:0] keep_data;

        model_reset();

        // ---------------- reset with arbitrary inputs ----------------
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h5C; d1 = 8'hC5;
        txrdy = 1'b1; rxrdy = 1'b1; rx_ready = 1'b1; dout = 8'hFF;
        repeat (3) step();
        check_val("reset_values", 32'({csn, wen, oen, r0, r1, din, rxv}),
                  32'({3'b111, 2'b00, 8'h00, 1'b0}));
        v0 = 1'b0; v1 = 1'b0; txrdy = 1'b0; rxrdy = 1'b0; rx_ready = 1'b0;
        rst_n = 1'b1;
        repeat (2) step();

        // ---------------- single write and spacing ----------------
        wr_log.delete(); n_r0 = 0; first_r = -1; second_r = -1;
        v0 = 1'b1; d0 = 8'hA5; txrdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (r0) begin
                if (first_r < 0) begin first_r = edge_n; d0 = 8'h5A; end
                else if (second_r < 0) begin second_r = edge_n; v0 = 1'b0; end
            end
        end
        check_val("single_count", 32'(wr_log.size()), 32'd2);
        check_val("single_ready_count", 32'(n_r0), 32'd2);
        if (wr_log.size() >= 2) begin
            check_val("single_data", 32'(wr_log[0]), 32'hA5);
            check_val("second_data", 32'(wr_log[1]), 32'h5A);
        end
        check_val("spacing", 32'(second_r - first_r), 32'(2 + TXW));

        // ---------------- round-robin from reset ----------------
        reset_now();
        release_reset();
        wr_log.delete(); n_r0 = 0; n_r1 = 0;
        v0 = 1'b1; d0 = 8'h11; v1 = 1'b1; d1 = 8'h22; txrdy = 1'b1;
        for (int i = 0; i < 40 && wr_log.size() < 4; i++) step();
        v0 = 1'b0; v1 = 1'b0;
        check_val("rr_count", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() >= 4) begin
            check_val("rr_order", 32'({wr_log[0], wr_log[1], wr_log[2], wr_log[3]}), 32'h11221122);
        end
        check_val("rr_ready_per_write", 32'(n_r0 + n_r1), 32'(wr_log.size()));
        repeat (6) step();

        // ---------------- read with parity error ----------------
        n_oen = 0;
        rxrdy = 1'b1; dout = 8'h3C; {fe, pe, ov} = 3'b010; rx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!oen) rxrdy = 1'b0;
        end
        check_val("rd_oen_count", 32'(n_oen), 32'd1);
        check_val("rd_hold", 32'({rxv, rxd, rxe}), 32'({1'b1, 8'h3C, 3'b010}));
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0; pe = 1'b0;
        step();
        check_val("rd_consumed", 32'(rxv), 32'd0);

        // ---------------- backpressure and read priority ----------------
        n_oen = 0; wr_log.delete();
        rxrdy = 1'b1; dout = 8'h77; rx_ready = 1'b0;
        v1 = 1'b1; d1 = 8'hC3; txrdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (r1) v1 = 1'b0;
        end
        check_val("bp_reads", 32'(n_oen), 32'd1);
        check_val("bp_writes", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() >= 1) check_val("bp_wdata", 32'(wr_log[0]), 32'hC3);
        check_val("bp_order", 32'(last_wr_edge > last_rd_edge), 32'd1);
        rx_ready = 1'b1;
        repeat (8) step();
        check_val("bp_resume", 32'(n_oen >= 2), 32'd1);
        rxrdy = 1'b0;
        repeat (6) step();
        rx_ready = 1'b0;

        // ---------------- reset mid-write ----------------
        v0 = 1'b1; d0 = 8'h96; v1 = 1'b1; d1 = 8'h69; txrdy = 1'b1;
        wait_ready(g0, g1, ok);
        check_val("mw_grant_tmo", 32'(ok), 32'd1);
        // granted request is consumed; reset lands in TXHOLD
        if (g0) v0 = 1'b0;
        if (g1) v1 = 1'b0;
        keep_data = g0 ? 8'h69 : 8'h96;
        step();
        reset_now();
        release_reset();
        wr_log.delete();
        wait_ready(g0, g1, ok);
        check_val("mw_regrant_tmo", 32'(ok), 32'd1);
        step();
        check_val("mw_regrant_data", 32'(wr_log.size() > 0 ? wr_log[0] : 8'h00), 32'(keep_data));
        // reset while the write strobe itself is low
        v0 = 1'b0; v1 = 1'b0;
        repeat (5) step();
        v0 = 1'b1; d0 = 8'hE1;
        wait_ready(g0, g1, ok);
        check_val("mw2_grant_tmo", 32'(ok), 32'd1);
        reset_now();
        release_reset();
        v0 = 1'b0;
        repeat (5) step();

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            step();
            drive_random();
            if ($urandom_range(0, 499) == 0) begin
                reset_now();
                release_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
